// File: rtl/uart_wb_pkg.sv
// Shared definitions for the UART-to-Wishbone command engine: command codes,
// FSM state encoding and frame geometry.
package uart_wb_pkg;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  localparam int ADDR_BYTES = 4;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    SIZE,
    ADDR,
    WDATA,
    WB,
    RESP
  } stateT;

  // Next word address; the low two bits ride along untouched and the upper bits wrap.
  function automatic logic [31:0] nextWordAddr(input logic [31:0] a);
    return {a[31:2] + 30'd1, a[1:0]};
  endfunction

endpackage

// File: rtl/uart_wb_byte_shift.sv
// 32-bit MSB-first byte shift register with a byte counter; done pulses on the
// byte that completes a word. A parallel load lets the owner overwrite the word.
module uart_wb_byte_shift
  import uart_wb_pkg::*;
#(
  parameter int NBYTES = WORD_BYTES
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        shift,
  input  logic [7:0]  din,
  input  logic        load,
  input  logic [31:0] loadVal,
  output logic [31:0] data,
  output logic        done
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [CW-1:0] cnt;

  assign done = shift && (cnt == CW'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      if (clear) begin
        cnt <= '0;
      end else if (shift) begin
        cnt <= done ? '0 : cnt + 1'b1;
      end
      if (load) begin
        data <= loadVal;
      end else if (shift) begin
        data <= {data[23:0], din};
      end
    end
  end

endmodule

// File: rtl/uart_wb_cmd_engine.sv
// Host frame parser and Wishbone master for the debug UART bridge.
// Optional WB_TIMEOUT_EN: bounds each bus cycle and substitutes ERR_WORD on read timeout.
module uart_wb_cmd_engine
  import uart_wb_pkg::*;
#(
  parameter int          RX_GAP_CYC = 1000000,
  parameter int          WB_TIMEOUT = 1024,
  parameter logic [31:0] ERR_WORD   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        ovr_o
);

  localparam int GAPW = $clog2(RX_GAP_CYC + 1);

  stateT         state, nextState;
  logic          isWrite;
  logic [7:0]    wordsLeft;
  logic [GAPW-1:0] gapCnt;
  logic [1:0]    byteIdx;
  logic [31:0]   rdData;
  logic          ovr;

  logic inFrame, gapExpired, lastWord, txFire, lastByte;
  logic addrShift, addrDone, addrLoad, datShift, datDone;
  logic wbDone;
  logic [31:0] wbWord;

  assign inFrame    = (state == SIZE) || (state == ADDR) || (state == WDATA);
  assign gapExpired = inFrame && !rx_valid && (gapCnt == GAPW'(RX_GAP_CYC - 1));
  assign lastWord   = (wordsLeft == 8'd1);
  assign txFire     = tx_valid && tx_ready;
  assign lastByte   = (state == RESP) && txFire && (byteIdx == 2'd3);
  assign addrShift  = (state == ADDR) && rx_valid;
  assign datShift   = (state == WDATA) && rx_valid;
  assign addrLoad   = ((state == WB) && wbDone && isWrite && !lastWord) ||
                      (lastByte && !lastWord);

`ifdef WB_TIMEOUT_EN
  localparam int TOW = $clog2(WB_TIMEOUT + 1);

  logic [TOW-1:0] toCnt;
  logic           timedOut;

  assign timedOut = (state == WB) && !wbm_ack_i && (toCnt == TOW'(WB_TIMEOUT - 1));
  assign wbDone   = wbm_ack_i || timedOut;
  assign wbWord   = wbm_ack_i ? wbm_dat_i : ERR_WORD;

  always_ff @(posedge clk) begin
    if (!resetn || (state != WB) || wbDone) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCnt + 1'b1;
    end
  end
`else
  logic unusedTimeoutParams;

  assign unusedTimeoutParams = ^{WB_TIMEOUT, ERR_WORD};
  assign wbDone = wbm_ack_i;
  assign wbWord = wbm_dat_i;
`endif

  uart_wb_byte_shift #(.NBYTES(ADDR_BYTES)) addrReg (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state == IDLE),
    .shift   (addrShift),
    .din     (rx_data),
    .load    (addrLoad),
    .loadVal (nextWordAddr(wbm_adr_o)),
    .data    (wbm_adr_o),
    .done    (addrDone)
  );

  uart_wb_byte_shift #(.NBYTES(WORD_BYTES)) wdataReg (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (state == IDLE),
    .shift   (datShift),
    .din     (rx_data),
    .load    (1'b0),
    .loadVal (32'h0),
    .data    (wbm_dat_o),
    .done    (datDone)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:  if (rx_valid && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) nextState = SIZE;
      SIZE:  if (rx_valid) nextState = (rx_data == 8'h00) ? IDLE : ADDR;
             else if (gapExpired) nextState = IDLE;
      ADDR:  if (addrDone) nextState = isWrite ? WDATA : WB;
             else if (gapExpired) nextState = IDLE;
      WDATA: if (datDone) nextState = WB;
             else if (gapExpired) nextState = IDLE;
      WB:    if (wbDone) nextState = !isWrite ? RESP : (lastWord ? IDLE : WDATA);
      RESP:  if (lastByte) nextState = lastWord ? IDLE : WB;
      default: nextState = IDLE;
    endcase
  end

  // A byte arriving while the bus or the response owns the engine cannot be held, so it is flagged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      isWrite   <= 1'b0;
      wordsLeft <= '0;
      gapCnt    <= '0;
      byteIdx   <= '0;
      rdData    <= '0;
      ovr       <= 1'b0;
    end else begin
      state <= nextState;
      if ((state == IDLE) && rx_valid) isWrite <= (rx_data == CMD_WR);
      if ((state == SIZE) && rx_valid) begin
        wordsLeft <= rx_data;
      end else if (((state == WB) && wbDone && isWrite) || lastByte) begin
        wordsLeft <= wordsLeft - 1'b1;
      end
      if (!inFrame || rx_valid) gapCnt <= '0;
      else gapCnt <= gapCnt + 1'b1;
      if ((state == WB) && wbDone && !isWrite) begin
        rdData  <= wbWord;
        byteIdx <= '0;
      end else if ((state == RESP) && txFire) begin
        rdData  <= {rdData[23:0], 8'h00};
        byteIdx <= byteIdx + 1'b1;
      end
      if (((state == WB) || (state == RESP)) && rx_valid) ovr <= 1'b1;
    end
  end

  assign wbm_cyc_o = (state == WB);
  assign wbm_stb_o = (state == WB);
  assign wbm_we_o  = (state == WB) && isWrite;
  assign wbm_sel_o = (state == WB) ? 4'hF : 4'h0;
  assign tx_valid  = (state == RESP);
  assign tx_data   = (state == RESP) ? rdData[31:24] : 8'h00;
  assign busy_o    = (state != IDLE);
  assign ovr_o     = ovr;

endmodule

// File: tb/tb_uart_wb_cmd_engine.sv
// Self-checking bench for uart_wb_cmd_engine: table-driven frames with a bus and
// tx scoreboard, plus hand sequences for gap, stall/overrun, reset and timeout.
module tb_uart_wb_cmd_engine;

  localparam int GAP = 40;
  localparam int TMO = 16;

  logic        clk;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o, ovr_o;

  uart_wb_cmd_engine #(.RX_GAP_CYC(GAP), .WB_TIMEOUT(TMO), .ERR_WORD(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy_o(busy_o), .ovr_o(ovr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } busT;

  typedef struct {
    bit          isWrite;
    logic [7:0]  size;
    logic [31:0] addr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] expAdr1;
  } vecT;

  busT         busQ[$];
  logic [7:0]  txQ[$];
  logic [31:0] rdQ[$];
  vecT         vecs[5];

  int checks = 0;
  int errors = 0;
  bit slaveEn = 1'b1;
  bit forceAck = 1'b0;
  int ackLatency = 1;
  int waitCnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: event seen with nothing expected", name);
  endtask

  // Wishbone slave: acks after ackLatency cycles and checks each cycle against busQ.
  initial begin
    busT e;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
      end else if (forceAck) begin
        wbm_ack_i = 1'b1;
        forceAck  = 1'b0;
      end else if (slaveEn && wbm_cyc_o && wbm_stb_o) begin
        if (waitCnt < ackLatency) begin
          waitCnt++;
        end else begin
          waitCnt = 0;
          if (busQ.size() == 0) begin
            unexpected("bus cycle");
          end else begin
            e = busQ.pop_front();
            checkOutput("bus we", {31'h0, wbm_we_o}, {31'h0, e.we});
            checkOutput("bus adr", wbm_adr_o, e.adr);
            checkOutput("bus sel", {28'h0, wbm_sel_o}, 32'hF);
            if (e.we) checkOutput("bus dat_o", wbm_dat_o, e.dat);
            else if (rdQ.size() != 0) wbm_dat_i = rdQ.pop_front();
          end
          wbm_ack_i = 1'b1;
        end
      end
    end
  end

  // Transmit sink: every handshake must match the next expected byte.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (txQ.size() == 0) begin
          unexpected("tx byte");
        end else begin
          b = txQ.pop_front();
          checkOutput("tx byte", {24'h0, tx_data}, {24'h0, b});
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic sendAddr(input logic [31:0] a);
    for (int i = 0; i < 4; i++) sendByte(a[31 - 8*i -: 8]);
  endtask

  task automatic waitBusIdle();
    int n = 0;
    while (wbm_cyc_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) unexpected("bus cycle never ended");
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " busy"}, {31'h0, busy_o}, 32'h0);
    checkOutput({name, " drained"}, busQ.size() + txQ.size(), 32'h0);
  endtask

  task automatic applyStimulus(input vecT v);
    logic [31:0] w, a;
    for (int k = 0; k < v.size; k++) begin
      w = (k == 0) ? v.d0 : v.d1;
      a = (k == 0) ? v.addr : v.expAdr1;
      if (v.isWrite) begin
        busQ.push_back('{1'b1, a, w});
      end else begin
        busQ.push_back('{1'b0, a, 32'h0});
        rdQ.push_back(w);
        for (int i = 0; i < 4; i++) txQ.push_back(w[31 - 8*i -: 8]);
      end
    end
    sendByte(v.isWrite ? 8'h01 : 8'h02);
    sendByte(v.size);
    sendAddr(v.addr);
    if (v.isWrite) begin
      for (int k = 0; k < v.size; k++) begin
        sendAddr((k == 0) ? v.d0 : v.d1);
        if (k == 0) checkOutput("cyc after last data byte", {31'h0, wbm_cyc_o}, 32'h1);
        if (k != v.size - 1) waitBusIdle();
      end
    end else begin
      checkOutput("cyc after last addr byte", {31'h0, wbm_cyc_o}, 32'h1);
    end
  endtask

  initial begin
    logic [7:0] held;
    int changes;
    int n;
    resetn   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    vecs[0] = '{1'b1, 8'd1, 32'h00400024, 32'h775555AB, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 8'd1, 32'h00400024, 32'h775555AB, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 8'd2, 32'h00400024, 32'h11223344, 32'hAABBCCDD, 32'h00400028};
    vecs[3] = '{1'b0, 8'd2, 32'hFFFFFFFC, 32'h01020304, 32'h05060708, 32'h00000000};
    vecs[4] = '{1'b1, 8'd2, 32'h12345673, 32'hCAFEF00D, 32'h0BADC0DE, 32'h12345677};

    repeat (3) @(negedge clk);
    checkOutput("reset cyc", {31'h0, wbm_cyc_o}, 32'h0);
    checkOutput("reset stb", {31'h0, wbm_stb_o}, 32'h0);
    checkOutput("reset we", {31'h0, wbm_we_o}, 32'h0);
    checkOutput("reset sel", {28'h0, wbm_sel_o}, 32'h0);
    checkOutput("reset adr", wbm_adr_o, 32'h0);
    checkOutput("reset dat_o", wbm_dat_o, 32'h0);
    checkOutput("reset tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("reset tx_data", {24'h0, tx_data}, 32'h0);
    checkOutput("reset busy", {31'h0, busy_o}, 32'h0);
    checkOutput("reset ovr", {31'h0, ovr_o}, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
      waitIdle($sformatf("vec%0d", i));
    end
    checkOutput("ovr after table", {31'h0, ovr_o}, 32'h0);

    $display("[TB] stray byte then read");
    sendByte(8'h07);
    checkOutput("stray byte busy", {31'h0, busy_o}, 32'h0);
    applyStimulus(vecs[1]);
    waitIdle("read after stray");
    checkOutput("stray ovr", {31'h0, ovr_o}, 32'h0);

    $display("[TB] zero size frame");
    sendByte(8'h01);
    sendByte(8'h00);
    checkOutput("size zero busy", {31'h0, busy_o}, 32'h0);
    repeat (10) @(negedge clk);

    $display("[TB] partial frame gap");
    sendByte(8'h01);
    sendByte(8'h01);
    sendByte(8'h00);
    sendByte(8'h40);
    repeat (GAP - 1) @(negedge clk);
    checkOutput("gap not yet expired", {31'h0, busy_o}, 32'h1);
    @(negedge clk);
    checkOutput("gap expired", {31'h0, busy_o}, 32'h0);
    applyStimulus(vecs[0]);
    waitIdle("write after gap");

    $display("[TB] tx stall and overrun");
    tx_ready = 1'b0;
    applyStimulus(vecs[1]);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall tx_valid", {31'h0, tx_valid}, 32'h1);
    checkOutput("stall first byte", {24'h0, tx_data}, 32'h77);
    held = tx_data;
    sendByte(8'h55);
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_data !== held || tx_valid !== 1'b1) changes++;
    end
    checkOutput("tx_data held", changes, 32'h0);
    checkOutput("ovr set in RESP", {31'h0, ovr_o}, 32'h1);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    waitIdle("stalled read");
    checkOutput("ovr sticky", {31'h0, ovr_o}, 32'h1);

    $display("[TB] reset mid-cycle and late ack");
    slaveEn = 1'b0;
    sendByte(8'h01);
    sendByte(8'h01);
    sendAddr(32'h00000100);
    sendAddr(32'h12345678);
    checkOutput("stalled cyc", {31'h0, wbm_cyc_o}, 32'h1);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("mid reset cyc", {31'h0, wbm_cyc_o}, 32'h0);
    checkOutput("mid reset stb", {31'h0, wbm_stb_o}, 32'h0);
    checkOutput("mid reset ovr", {31'h0, ovr_o}, 32'h0);
    checkOutput("mid reset adr", wbm_adr_o, 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1 forceAck = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("late ack busy", {31'h0, busy_o}, 32'h0);
    checkOutput("late ack cyc", {31'h0, wbm_cyc_o}, 32'h0);
    slaveEn = 1'b1;
    applyStimulus(vecs[2]);
    waitIdle("burst after reset");

`ifdef WB_TIMEOUT_EN
    $display("[TB] read timeout");
    slaveEn = 1'b0;
    txQ.push_back(8'hDE);
    txQ.push_back(8'hAD);
    txQ.push_back(8'hBE);
    txQ.push_back(8'hEF);
    sendByte(8'h02);
    sendByte(8'h01);
    sendAddr(32'h00000200);
    n = 0;
    while (wbm_cyc_o && n < TMO * 4) begin
      n++;
      @(negedge clk);
    end
    checkOutput("timeout cyc length", n, TMO);
    slaveEn = 1'b1;
    waitIdle("timeout read");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_wb_cmd_engine.md
Name: uart_wb_cmd_engine

Overview:
Command engine of the debug UART-to-Wishbone bridge. It sits between the UART byte receiver/transmitter and the management Wishbone bus.
- Parses host byte frames: cmd, size, 4 address bytes, then data.
- Issues Wishbone master single or burst read/write cycles.
- Streams read data back to the UART transmitter, MSB byte first.

Parameters:
RX_GAP_CYC, 1000000, idle cycles mid-frame before the parser abandons the frame and returns to IDLE.
WB_TIMEOUT, 1024, cycles to wait for wbm_ack_i; used only when WB_TIMEOUT_EN is defined.
ERR_WORD, 32'hDEADBEEF, data returned for a timed-out read.

Ports:
clk  in  1  single clock for the block
resetn  in  1  reset, synchronous, active-low
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure possible
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects, always 4'hF during a cycle
wbm_adr_o  out  32  byte address
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_ack_i  in  1  acknowledge
busy_o  out  1  high whenever state != IDLE
ovr_o  out  1  sticky overrun flag: rx byte arrived while not accepting

Behaviour:
- Reset, sampled on the clk edge with resetn=0, applies to every output:
  - outputs: cyc/stb/we/tx_valid/busy_o/ovr_o=0, adr/dat_o=0, sel=0, tx_data=0
  - state: IDLE, all counters 0
- States: IDLE, SIZE, ADDR, WDATA, WB, RESP.
- IDLE:
  - rx 0x01 -> SIZE (write); rx 0x02 -> SIZE (read).
  - Any other byte is ignored; state stays IDLE; ovr_o is not set.
- SIZE:
  - Byte N = word count 1..255. N=0 aborts to IDLE with no bus cycle.
- ADDR:
  - 4 bytes, MSB first, shifted into the address register.
  - After the 4th byte: write -> WDATA; read -> WB.
- WDATA:
  - 4 bytes, MSB first, shifted into wbm_dat_o.
  - After the 4th byte -> WB. cyc/stb/we asserted the cycle after the 4th rx_valid.
- WB:
  - cyc=stb=1, sel=F, adr held, until wbm_ack_i is sampled high.
  - cyc/stb deassert in the cycle after the ack (registered). One bus cycle per word, no pipelining.
  - Read: wbm_dat_i captured on the ack cycle -> RESP.
  - Write after ack: remaining words>0 -> adr+=4, WDATA; else IDLE.
- RESP:
  - tx_valid=1 with byte3 in the cycle after the ack; then bytes 2,1,0.
  - Advance one byte per tx_valid&tx_ready; tx_data stable while tx_ready=0.
  - After byte0: remaining words>0 -> adr+=4, WB; else IDLE.
- Address arithmetic:
  - 32-bit, wraps FFFFFFFC -> 00000000.
  - Low 2 bits are passed through unchanged.
- Gap timer:
  - Counts cycles without rx_valid while in SIZE/ADDR/WDATA.
  - Reaching RX_GAP_CYC -> IDLE, frame discarded, no bus cycle.
  - Reset on every accepted byte.
- Overrun:
  - An rx_valid in WB or RESP is dropped and sets ovr_o. ovr_o clears only on reset.
- Reset mid-cycle:
  - cyc/stb drop in the reset cycle.
  - A late ack while in IDLE is ignored.

Optional Feature:
WB_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WB. Reaching WB_TIMEOUT without ack drops cyc/stb.
  - Read: ERR_WORD is returned via RESP.
  - Write: the burst continues as if acked.
- Undefined: WB waits for ack indefinitely; no counter logic is present.

Decomposition:
- Shared package uart_wb_pkg holds:
  - command codes CMD_WR=8'h01, CMD_RD=8'h02
  - state encoding enum
  - ADDR_BYTES=4, WORD_BYTES=4
- One natural sub-module: uart_wb_byte_shift, a 32-bit byte shift register with count/done, instantiated for address and write data.
- Response serializer stays inline.

Test Plan:
- Write cmd 01 01 00 40 00 24 77 55 55 AB -> one cycle: adr=00400024, dat_o=775555AB, we=1, sel=F; idle after ack.
- Read cmd 02 01 00 40 00 24, slave returns 775555AB -> tx bytes 77,55,55,AB in order; busy_o falls after the last handshake.
- Burst write size 02 at 00400024, data 11223344 AABBCCDD -> adr 00400024 then 00400028, two acks.
- Stray 0x07 in IDLE, then a valid read -> 0x07 ignored, read completes; ovr_o=0.
- Partial frame 01 01 00 40 followed by RX_GAP_CYC idle cycles -> IDLE, no cyc; a subsequent full write succeeds.
- With tx_ready held 0 for 50 cycles during RESP -> tx_data held; a byte injected during RESP sets ovr_o=1.
- WB_TIMEOUT_EN, read with no ack -> cyc drops after WB_TIMEOUT cycles; tx bytes DE AD BE EF.
